// File: rtl/bus_ac_datapath.sv
// A-bus and B-bus source muxes plus the accumulator (AC) register for the down-sampling processor.
// AC loads from the ALU result, data memory or coefficient memory. It drives the A-bus and the DM write port.
module bus_ac_datapath #(
    parameter int DATA_W = 32,
    parameter int DM_W   = 8,
    parameter int CM_W   = 20
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [2:0]        abus_en,
    input  logic [2:0]        bbus_en,
    input  logic [3:0]        cbus_en,
    input  logic              ac_clr,
    input  logic              dm_r,
    input  logic              cm_r,
    input  logic              dm_wr,
    input  logic [DATA_W-1:0] cbus,
    input  logic [DM_W-1:0]   dm_out,
    input  logic [CM_W-1:0]   cm_out,
    input  logic [DATA_W-1:0] ir_a,
    input  logic [DATA_W-1:0] mar,
    input  logic [DATA_W-1:0] sor,
    input  logic [DATA_W-1:0] dstr,
    input  logic [DATA_W-1:0] coun,
    input  logic [DATA_W-1:0] reg1,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] reg3,
    input  logic [DATA_W-1:0] ir_b,
    output logic [DATA_W-1:0] abus_out,
    output logic [DATA_W-1:0] bbus_out,
    output logic [DATA_W-1:0] ac_q,
    output logic [DM_W-1:0]   dm_in
);

    localparam logic [3:0] CBUS_AC = 4'd6;

    logic [DATA_W-1:0] ac_d;

    always_comb begin
        abus_out = '0;
        unique case (abus_en)
            3'd1:    abus_out = ir_a;
            3'd2:    abus_out = mar;
            3'd3:    abus_out = sor;
            3'd4:    abus_out = dstr;
            3'd5:    abus_out = coun;
            3'd6:    abus_out = ac_q;
            default: abus_out = '0;
        endcase
    end

    always_comb begin
        bbus_out = '0;
        unique case (bbus_en)
            3'd1:    bbus_out = reg1;
            3'd2:    bbus_out = reg2;
            3'd3:    bbus_out = reg3;
            3'd4:    bbus_out = ir_b;
            default: bbus_out = '0;
        endcase
    end

    // Memory loads outrank the C-bus load, and DM outranks CM.
    always_comb begin
        ac_d = ac_q;
        if (ac_clr)
            ac_d = '0;
        else if (dm_r)
            ac_d = {{(DATA_W-DM_W){1'b0}}, dm_out};
        else if (cm_r)
            ac_d = {{(DATA_W-CM_W){1'b0}}, cm_out};
        else if (cbus_en == CBUS_AC)
            ac_d = cbus;
    end

    always_ff @(posedge clock) begin
        if (!rst_n)
            ac_q <= '0;
        else
            ac_q <= ac_d;
    end

    // This reads the registered AC, so a write in the same cycle as a load sends the old byte.
    assign dm_in = dm_wr ? ac_q[DM_W-1:0] : '0;

endmodule

// File: tb/tb_bus_ac_datapath.sv
// Scoreboard bench for bus_ac_datapath: the stimulus process queues expected values with a due cycle,
// and a monitor pops and compares them on the falling edge.
module tb_bus_ac_datapath;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [2:0]  abus_en, bbus_en;
    logic [3:0]  cbus_en;
    logic        ac_clr, dm_r, cm_r, dm_wr;
    logic [31:0] cbus;
    logic [7:0]  dm_out;
    logic [19:0] cm_out;
    logic [31:0] ir_a, mar, sor, dstr, coun, reg1, reg2, reg3, ir_b;
    logic [31:0] abus_out, bbus_out, ac_q;
    logic [7:0]  dm_in;

    bus_ac_datapath dut (
        .clock(clock), .rst_n(rst_n), .abus_en(abus_en), .bbus_en(bbus_en),
        .cbus_en(cbus_en), .ac_clr(ac_clr), .dm_r(dm_r), .cm_r(cm_r), .dm_wr(dm_wr),
        .cbus(cbus), .dm_out(dm_out), .cm_out(cm_out), .ir_a(ir_a), .mar(mar),
        .sor(sor), .dstr(dstr), .coun(coun), .reg1(reg1), .reg2(reg2), .reg3(reg3),
        .ir_b(ir_b), .abus_out(abus_out), .bbus_out(bbus_out), .ac_q(ac_q), .dm_in(dm_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        int          kind;   // 0 abus, 1 bbus, 2 ac_q, 3 dm_in
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                0:       act = abus_out;
                1:       act = bbus_out;
                2:       act = ac_q;
                default: act = {24'h0, dm_in};
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_now(int kind, logic [31:0] v, string name);
        exp_t e;
        e.due = cyc; e.kind = kind; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_next(int kind, logic [31:0] v, string name);
        exp_t e;
        e.due = cyc + 1; e.kind = kind; e.exp = v; e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle_ctrl();
        cbus_en = 4'd0; ac_clr = 0; dm_r = 0; cm_r = 0; dm_wr = 0;
    endtask

    logic [31:0] a_tab [8];
    logic [31:0] b_tab [8];

    initial begin
        a_tab = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd0};
        b_tab = '{32'd0, 32'd11, 32'd12, 32'd13, 32'd14, 32'd0, 32'd0, 32'd0};

        rst_n = 0; abus_en = 0; bbus_en = 0; idle_ctrl();
        cbus = 32'h0; dm_out = 8'h0; cm_out = 20'h0;
        ir_a = 1; mar = 2; sor = 3; dstr = 4; coun = 5;
        reg1 = 11; reg2 = 12; reg3 = 13; ir_b = 14;

        step(); step();
        dm_wr = 1;
        expect_now(2, 32'h0, "reset_ac");
        expect_now(3, 32'h0, "reset_dm_in");
        step();
        rst_n = 1; dm_wr = 0;

        // Mux sweeps, one select code per cycle; AC is still zero so A-bus code 6 reads zero.
        for (int i = 0; i < 8; i++) begin
            step();
            abus_en = 3'(i);
            bbus_en = 3'(i);
            expect_now(0, a_tab[i], $sformatf("abus_sel%0d", i));
            expect_now(1, b_tab[i], $sformatf("bbus_sel%0d", i));
        end

        // C-bus load, then a non-AC destination must hold the value.
        step();
        abus_en = 3'd6;
        cbus = 32'hDEADBEEF; cbus_en = 4'd6;
        expect_now(0, 32'h0, "abus_ac_before_load");
        expect_next(2, 32'hDEADBEEF, "cbus_load");
        step();
        cbus = 32'h0; cbus_en = 4'd5;
        expect_now(0, 32'hDEADBEEF, "abus_ac_after_load");
        expect_next(2, 32'hDEADBEEF, "cbus_en5_hold");
        step();
        cbus_en = 4'd7;
        expect_next(2, 32'hDEADBEEF, "cbus_en7_hold");

        // Memory loads are zero-extended.
        step();
        cbus_en = 4'd0; dm_r = 1; dm_out = 8'hA5;
        expect_next(2, 32'h000000A5, "dm_load");
        step();
        dm_r = 0; cm_r = 1; cm_out = 20'hFFFFF;
        expect_next(2, 32'h000FFFFF, "cm_load");

        // Priority checks.
        step();
        dm_r = 1; cm_r = 1; cbus_en = 4'd6;
        dm_out = 8'h3C; cm_out = 20'h12345; cbus = 32'hCAFEF00D;
        expect_next(2, 32'h0000003C, "prio_dm_over_cm_cbus");
        step();
        dm_r = 0;
        expect_next(2, 32'h00012345, "prio_cm_over_cbus");
        step();
        cm_r = 0; cbus_en = 4'd0; ac_clr = 1; dm_r = 1; dm_out = 8'h77;
        expect_next(2, 32'h0, "prio_clr_over_dm");

        // Write path, including a write issued in the same cycle as a load.
        step();
        ac_clr = 0; dm_r = 0; cbus = 32'h12345678; cbus_en = 4'd6;
        expect_next(2, 32'h12345678, "load_12345678");
        step();
        cbus_en = 4'd0; dm_wr = 1;
        expect_now(3, 32'h78, "dm_wr_byte");
        expect_next(2, 32'h12345678, "dm_wr_no_modify");
        step();
        cbus = 32'hAABBCCDD; cbus_en = 4'd6;
        expect_now(3, 32'h78, "dm_wr_preload_byte");
        step();
        cbus_en = 4'd0;
        expect_now(3, 32'hDD, "dm_wr_after_load");
        step();
        dm_wr = 0;
        expect_now(3, 32'h0, "dm_wr_off");

        // Reset overrides a pending C-bus load; the buses keep following their inputs.
        step();
        rst_n = 0; cbus = 32'h55555555; cbus_en = 4'd6; dm_wr = 1; abus_en = 3'd2; bbus_en = 3'd3;
        expect_now(2, 32'hAABBCCDD, "ac_before_reset");
        expect_now(0, 32'd2, "abus_in_reset");
        expect_now(1, 32'd13, "bbus_in_reset");
        expect_next(2, 32'h0, "reset_overrides_load");
        expect_next(3, 32'h0, "reset_dm_in_zero");
        step();
        rst_n = 1; idle_ctrl();

        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        if (sb.size() > 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
            n_checks++;
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
